// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle HI/LO unit.
//   - md_op encodings presented by the EX stage
//   - FSM state encodings
//   - default operand width
//   - is_md_multicycle(): true for the ops that run the iterative datapath
package muldiv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   // Which iteration the datapath performs.
   typedef enum logic {
      CLS_MUL = 1'b0,
      CLS_DIV = 1'b1
   } md_cls_e;

   function automatic logic is_md_multicycle(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) ||
             (op == MD_DIV)  || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration step of the unsigned multiply / divide datapath (combinational).
// Ports:
//   i_cls    : CLS_MUL (shift-add) or CLS_DIV (restoring divide)
//   i_acc_hi : upper accumulator (partial product high half / partial remainder)
//   i_acc_lo : lower accumulator (multiplier bits / dividend bits + quotient)
//   i_opnd   : multiplicand (MUL) or divisor (DIV) magnitude
//   o_acc_hi : next upper accumulator
//   o_acc_lo : next lower accumulator
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  md_cls_e          i_cls,
   input  logic [XLEN-1:0]  i_acc_hi,
   input  logic [XLEN-1:0]  i_acc_lo,
   input  logic [XLEN-1:0]  i_opnd,
   output logic [XLEN-1:0]  o_acc_hi,
   output logic [XLEN-1:0]  o_acc_lo
);

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_shift;
   logic [XLEN-1:0] w_diff;
   logic            w_ge;

   always_comb begin
      // Multiply: add multiplicand when the current multiplier LSB is set, then
      // shift the {carry,hi,lo} chain right so the next multiplier bit lands in lo[0].
      w_sum   = {1'b0, i_acc_hi} + {1'b0, (i_acc_lo[0] ? i_opnd : '0)};
      // Divide: bring the next dividend bit into the remainder, trial subtract.
      // A successful subtract always leaves a value below the divisor, so the
      // low XLEN bits of the difference are exact.
      w_shift = {i_acc_hi, i_acc_lo[XLEN-1]};
      w_ge    = (w_shift >= {1'b0, i_opnd});
      w_diff  = w_shift[XLEN-1:0] - i_opnd;

      o_acc_hi = '0;
      o_acc_lo = '0;
      if (i_cls == CLS_MUL) begin
         o_acc_hi = w_sum[XLEN:1];
         o_acc_lo = {w_sum[0], i_acc_lo[XLEN-1:1]};
      end else begin
         o_acc_hi = w_ge ? w_diff : w_shift[XLEN-1:0];
         o_acc_lo = {i_acc_lo[XLEN-2:0], w_ge};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO unit for the EX stage: sequences MULT/MULTU/DIV/DIVU one
// result bit per cycle, handles MTHI/MTLO, owns HI/LO and stalls the pipeline.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start, md_op   : EX-stage request and operation (sampled only in IDLE)
//   src_a, src_b   : rs / rt operands
//   flush          : abort the running operation, no HI/LO write
//   stall          : hold IF..EX while an operation is accepted or running
//   done           : one-cycle pulse in the cycle HI/LO hold a new mul/div result
//   hi, lo         : HI and LO registers
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      md_op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            flush,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(XLEN);

   logic [1:0]      r_state;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_acc_hi;
   logic [XLEN-1:0] r_acc_lo;
   logic [XLEN-1:0] r_opnd;
   logic [XLEN-1:0] r_a_raw;
   md_cls_e         r_cls;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_divz;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic            r_done;

   logic            w_accept;
   logic            w_signed;
   logic            w_is_div;
   logic [XLEN-1:0] w_mag_a;
   logic [XLEN-1:0] w_mag_b;
   logic [XLEN-1:0] w_nxt_hi;
   logic [XLEN-1:0] w_nxt_lo;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0] w_quo;
   logic [XLEN-1:0] w_rem;

   assign w_accept = (r_state == ST_IDLE) && start && is_md_multicycle(md_op) && !flush;
   assign w_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
   assign w_is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
   assign w_mag_a  = (w_signed && src_a[XLEN-1]) ? -src_a : src_a;
   assign w_mag_b  = (w_signed && src_b[XLEN-1]) ? -src_b : src_b;

   // Sign correction applied at write-back.
   assign w_prod = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
   assign w_quo  = r_neg_q ? -r_acc_lo : r_acc_lo;
   assign w_rem  = r_neg_r ? -r_acc_hi : r_acc_hi;

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .i_cls    (r_cls),
      .i_acc_hi (r_acc_hi),
      .i_acc_lo (r_acc_lo),
      .i_opnd   (r_opnd),
      .o_acc_hi (w_nxt_hi),
      .o_acc_lo (w_nxt_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_opnd   <= '0;
         r_a_raw  <= '0;
         r_cls    <= CLS_MUL;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_divz   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == ST_FIX) && !flush;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state  <= ST_CALC;
                  r_cnt    <= '0;
                  r_acc_hi <= '0;
                  r_acc_lo <= w_is_div ? w_mag_a : w_mag_b;
                  r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
                  r_a_raw  <= src_a;
                  r_cls    <= w_is_div ? CLS_DIV : CLS_MUL;
                  r_neg_q  <= w_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                  r_neg_r  <= w_signed && src_a[XLEN-1];
                  r_divz   <= w_is_div && (src_b == '0);
               end else if (start && !flush && (md_op == MD_MTHI)) begin
                  r_hi <= src_a;
               end else if (start && !flush && (md_op == MD_MTLO)) begin
                  r_lo <= src_a;
               end
            end
            ST_CALC: begin
               if (flush) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_acc_hi <= w_nxt_hi;
                  r_acc_lo <= w_nxt_lo;
                  r_cnt    <= r_cnt + CW'(1);
                  if (r_cnt == CW'(XLEN-1)) r_state <= ST_FIX;
               end
            end
            ST_FIX: begin
               r_state <= ST_IDLE;
               if (!flush) begin
                  if (r_cls == CLS_MUL) begin
                     {r_hi, r_lo} <= w_prod;
                  end else if (r_divz) begin
                     // Divide by zero: defined result, no sign fix.
                     r_lo <= '1;
                     r_hi <= r_a_raw;
                  end else begin
                     r_lo <= w_quo;
                     r_hi <= w_rem;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign stall = w_accept || (r_state == ST_CALC) || (r_state == ST_FIX);
   assign done  = r_done;
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
   localparam int XLEN = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_chk  = 0;
   int n_fail = 0;

   // Architectural model of HI/LO.
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   always #5 clk = ~clk;

   muldiv_ctrl #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .md_op (md_op),
      .src_a (src_a),
      .src_b (src_b),
      .flush (flush),
      .stall (stall),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference result {hi,lo} from plain integer arithmetic.
   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, p;
      int     ia, ib;
      logic [63:0] r;
      r = '0;
      case (op)
         3'd1: begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
            p  = sa * sb;
            r  = p;
         end
         3'd2: r = {32'd0, a} * {32'd0, b};
         3'd3: begin
            if (b == 0)                                  r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
            else begin
               ia = int'(a);
               ib = int'(b);
               r  = {32'(ia % ib), 32'(ia / ib)};
            end
         end
         3'd4: begin
            if (b == 0) r = {a, 32'hFFFF_FFFF};
            else        r = {a % b, a / b};
         end
         default: r = {m_hi, m_lo};
      endcase
      return r;
   endfunction

   // Full mul/div transaction with latency, stall and done checks.
   task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      int   n;
      logic seen_done;
      logic [63:0] e;
      e = ref_md(op, a, b);
      @(negedge clk);
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      #1;
      chk_eq({tag, "_stall_req"}, 64'(stall), 64'd1);
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      n = 0; seen_done = 1'b0;
      while (stall && n < 100) begin
         if (done) seen_done = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      chk_eq({tag, "_stall_cycles"}, 64'(n), 64'd33);
      chk_eq({tag, "_early_done"}, 64'(seen_done), 64'd0);
      chk_eq({tag, "_done"}, 64'(done), 64'd1);
      chk_eq({tag, "_hilo"}, {hi, lo}, e);
      m_hi = e[63:32];
      m_lo = e[31:0];
      @(posedge clk); #1;
      chk_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   // Start an op, flush it k edges after acceptance, confirm no write.
   task automatic md_flush(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int k);
      @(negedge clk);
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      repeat (k) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk_eq({tag, "_stall_busy"}, 64'(stall), 64'd1);
      @(posedge clk); #1;
      chk_eq({tag, "_stall"}, 64'(stall), 64'd0);
      chk_eq({tag, "_done"}, 64'(done), 64'd0);
      chk_eq({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
      @(negedge clk);
      flush = 1'b0;
      @(posedge clk); #1;
      chk_eq({tag, "_done_after"}, 64'(done), 64'd0);
      chk_eq({tag, "_hilo_after"}, {hi, lo}, {m_hi, m_lo});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      rst_n = 1'b0; start = 1'b0; md_op = 3'd0; src_a = '0; src_b = '0; flush = 1'b0;
      #2;
      chk_eq("rst_state", {30'd0, stall, done, hi, lo}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      md_run("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      md_run("mult_neg", 3'd1, 32'hFFFF_FFFF, 32'h0000_0007);
      md_run("div_neg", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
      md_run("divu_zero", 3'd4, 32'd100, 32'd0);
      md_run("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      md_run("div_zero_neg", 3'd3, 32'hFFFF_FF00, 32'd0);

      // Back-to-back MTHI / MTLO in IDLE.
      @(negedge clk);
      start = 1'b1; md_op = 3'd5; src_a = 32'h1234_5678;
      #1; chk_eq("mthi_stall", 64'(stall), 64'd0);
      @(negedge clk);
      md_op = 3'd6; src_a = 32'h9ABC_DEF0;
      #1; chk_eq("mtlo_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
      chk_eq("mthi_mtlo", {hi, lo}, {m_hi, m_lo});
      chk_eq("mt_done", 64'(done), 64'd0);

      md_flush("flush_calc", 3'd1, 32'h0000_1234, 32'h0000_5678, 10);
      md_flush("flush_fix", 3'd1, 32'h0000_1234, 32'h0000_5678, 32);

      // NONE / reserved with start, and MTHI blocked by flush: no effect.
      foreach (op[i]) ;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b1;
         md_op = (i == 0) ? 3'd0 : (i == 1) ? 3'd7 : 3'd5;
         flush = (i == 2);
         src_a = $urandom; src_b = $urandom;
         #1; chk_eq("noop_stall", 64'(stall), 64'd0);
         @(posedge clk); #1;
         chk_eq("noop_hilo", {hi, lo}, {m_hi, m_lo});
      end
      @(negedge clk);
      start = 1'b0; flush = 1'b0; md_op = 3'd0;

      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(1, 4));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         md_run("rand", op, a, b);
      end

      // Reset in the middle of a multiply.
      @(negedge clk);
      start = 1'b1; md_op = 3'd1; src_a = 32'h0000_0ABC; src_b = 32'h0000_0DEF;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_hi = '0; m_lo = '0;
      chk_eq("rst_mid_hilo", {hi, lo}, 64'd0);
      chk_eq("rst_mid_stall", 64'(stall), 64'd0);
      chk_eq("rst_mid_done", 64'(done), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      md_run("divu_9_4", 3'd4, 32'd9, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
